fixed_point_divider: RTL and testbench
======================================

Name: fixed_point_divider

Overview:
- Sequential signed fixed-point divider. Computes quotient = A / B on 16-bit two's-complement Q-format operands.
- Produces a rounded, saturated 16-bit two's-complement result with an enable/done handshake.
- Inverse of the team's fixed-point multiplier. Used in the spectrum path for magnitude normalisation and peak-ratio computation.
- Radix-2 restoring division on magnitudes; sign is applied at the end.

Parameters:
- EXP_WIDTH_A, 15: fractional bits of A.
- EXP_WIDTH_B, 15: fractional bits of B.
- EXP_WIDTH_QUOTIENT, 15: fractional bits of quotient.
- Derived S = EXP_WIDTH_QUOTIENT - EXP_WIDTH_A + EXP_WIDTH_B. Elaboration must fail if S < 0 or S > 16.
- Derived N = 16 + S, the iteration count (31 at defaults).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  start pulse; sampled only in IDLE.
- A  input  16  signed dividend.
- B  input  16  signed divisor.
- quotient  output  16  signed result; held until the next done.
- done  output  1  one-cycle pulse; quotient valid in the same cycle.
- busy  output  1  high from the cycle after enable is accepted until done.
- div_by_zero  output  1  valid with done; held with quotient.

Behaviour:
- Reset (reset=0, asynchronous):
  - quotient=0, done=0, busy=0, div_by_zero=0, state=IDLE.
  - Internal registers are cleared.
  - Deassertion is synchronised by the normal flop release; no special sequencing.
- States: IDLE, DIVIDE, FINISH.
- IDLE, enable=1 at edge k:
  - latch sign = A[15]^B[15], sign_a = A[15].
  - latch magA = |A| (17-bit safe, 0x8000 -> 32768) and magB = |B|.
  - numerator = magA << S (N bits); remainder=0; count=N.
  - bz = (B==0).
  - busy=1; go to DIVIDE.
  - enable=0: stay in IDLE.
  - done is always 0 in IDLE, except for the single cycle after FINISH.
- DIVIDE: one quotient bit per edge, MSB first.
  - rem' = {rem, next numerator bit}.
  - If rem' >= magB: rem' -= magB and shift in 1; else shift in 0.
  - count decrements; after N edges go to FINISH.
  - If bz, skip the iterations and go directly to FINISH.
- FINISH (one edge):
  - Rounding, half away from zero: mag_r = q_raw + (2*rem >= magB).
  - Saturation:
    - positive result: mag_r > 32767 -> 0x7FFF.
    - negative result: mag_r > 32768 -> 0x8000.
    - otherwise quotient = sign ? -mag_r : mag_r.
    - exact -32768 gives 0x8000 without overflow.
  - Divide by zero (bz):
    - A==0 -> quotient=0.
    - A>0 -> 0x7FFF.
    - A<0 -> 0x8000.
    - div_by_zero=1.
  - A==0 with B!=0 -> quotient=0 (never negative zero).
  - done=1 for exactly the cycle after the FINISH edge; busy=0 at that same edge; return to IDLE.
- Latency: enable sampled at edge k -> done and quotient valid after edge k+N+2.
  - Defaults: 33 cycles.
  - bz case: 2 cycles.
- Throughput:
  - A new enable may be accepted in the cycle done is high (state is IDLE).
  - enable while busy is ignored, with no effect on the operation in flight.
- A and B are sampled only at acceptance; later changes are ignored.
- Reset mid-operation: aborts immediately. Outputs return to reset values; no done is produced for the aborted operation.
- Remainder width is 17 bits to hold magB up to 32768 plus a shift. Quotient-raw width is N bits, then compared for saturation.

Optional Feature:
- Macro: FIXED_POINT_DIVIDER_OVERFLOW_FLAG_EN.
- Defined:
  - Adds output port overflow (1 bit).
  - Set with done when saturation occurred (not set for div-by-zero), held with quotient, reset to 0.
- Undefined: port absent; saturation still applied silently.

Test Plan (defaults, Q1.15):
- A=0x2000, B=0x4000 -> quotient=0x4000, div_by_zero=0; done exactly 33 cycles after enable; busy high for the intervening cycles.
- A=0x2000, B=0x6000 -> quotient=0x2AAB (10922.67 rounded up). A=0xE000, B=0x6000 -> quotient=0xD555.
- A=0xC000, B=0x4000 -> quotient=0x8000, overflow=0. A=0xC000, B=0x2000 -> 0x8000, overflow=1. A=0x4000, B=0x2000 -> 0x7FFF, overflow=1.
- Divide by zero:
  - B=0, A=0x1234 -> quotient=0x7FFF, div_by_zero=1, done 2 cycles after enable.
  - A=0xF000 -> 0x8000.
  - A=0 -> 0x0000.
- Back-to-back:
  - Second enable pulsed during busy with different operands -> ignored, first result correct.
  - Enable asserted in the done cycle -> accepted, next result after 33 cycles.
- Reset:
  - Assert reset 10 cycles into a divide -> quotient=0, busy=0 immediately, no done.
  - Release and divide 0x2000/0x4000 -> 0x4000.

Source files
------------

// File: rtl/fixed_point_divider.sv
// Sequential signed Q-format divider: radix-2 restoring division on magnitudes, round half away
// from zero, saturate. Define FIXED_POINT_DIVIDER_OVERFLOW_FLAG_EN to add the overflow output.
module fixed_point_divider #(
    parameter int unsigned EXP_WIDTH_A        = 15,
    parameter int unsigned EXP_WIDTH_B        = 15,
    parameter int unsigned EXP_WIDTH_QUOTIENT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] quotient,
    output logic        done,
    output logic        busy,
    output logic        div_by_zero
`ifdef FIXED_POINT_DIVIDER_OVERFLOW_FLAG_EN
    ,
    output logic        overflow
`endif
);

    localparam int S    = int'(EXP_WIDTH_QUOTIENT) - int'(EXP_WIDTH_A) + int'(EXP_WIDTH_B);
    localparam int N    = 16 + S;
    localparam int MagW = N + 1;
    localparam int CntW = $clog2(N + 1);

    if (S < 0 || S > 16) begin : g_bad_shift
        $fatal(1, "fixed_point_divider: derived shift out of range 0..16");
    end

    typedef enum logic [1:0] {StIdle, StDivide, StFinish} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    numer_q, numer_d;
    logic [N-1:0]    qraw_q, qraw_d;
    logic [16:0]     rem_q, rem_d;
    logic [15:0]     magb_q, magb_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sign_q, sign_d;
    logic            sign_a_q, sign_a_d;
    logic            a_zero_q, a_zero_d;
    logic            bz_q, bz_d;
    logic [15:0]     quotient_q, quotient_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;

    logic [15:0]     a_mag, b_mag;
    logic [17:0]     trial;
    logic            round_up;
    logic [N:0]      mag_r;

    // 16-bit unsigned negation maps 0x8000 to 32768 without needing a 17th bit.
    assign a_mag = A[15] ? (~A + 16'd1) : A;
    assign b_mag = B[15] ? (~B + 16'd1) : B;

    assign trial    = {rem_q, numer_q[N-1]};
    assign round_up = ({rem_q, 1'b0} >= {2'b00, magb_q});
    assign mag_r    = {1'b0, qraw_q} + {{N{1'b0}}, round_up};

    always_comb begin
        state_d    = state_q;
        numer_d    = numer_q;
        qraw_d     = qraw_q;
        rem_d      = rem_q;
        magb_d     = magb_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        sign_a_d   = sign_a_q;
        a_zero_d   = a_zero_q;
        bz_d       = bz_q;
        quotient_d = quotient_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    sign_d   = A[15] ^ B[15];
                    sign_a_d = A[15];
                    a_zero_d = (A == 16'd0);
                    magb_d   = b_mag;
                    numer_d  = N'(a_mag) << S;
                    rem_d    = '0;
                    qraw_d   = '0;
                    cnt_d    = CntW'(N);
                    bz_d     = (B == 16'd0);
                    busy_d   = 1'b1;
                    state_d  = StDivide;
                end
            end
            StDivide: begin
                // The count==0 pass is the extra edge that keeps latency at N+2.
                if (bz_q || cnt_q == '0) begin
                    state_d = StFinish;
                end else begin
                    if (trial >= {2'b00, magb_q}) begin
                        rem_d  = 17'(trial - {2'b00, magb_q});
                        qraw_d = {qraw_q[N-2:0], 1'b1};
                    end else begin
                        rem_d  = trial[16:0];
                        qraw_d = {qraw_q[N-2:0], 1'b0};
                    end
                    numer_d = {numer_q[N-2:0], 1'b0};
                    cnt_d   = cnt_q - CntW'(1);
                end
            end
            StFinish: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
                if (bz_q) begin
                    dbz_d = 1'b1;
                    ovf_d = 1'b0;
                    if (a_zero_q) begin
                        quotient_d = 16'h0000;
                    end else if (sign_a_q) begin
                        quotient_d = 16'h8000;
                    end else begin
                        quotient_d = 16'h7FFF;
                    end
                end else begin
                    dbz_d = 1'b0;
                    ovf_d = 1'b0;
                    if (!sign_q && mag_r > MagW'(32767)) begin
                        quotient_d = 16'h7FFF;
                        ovf_d      = 1'b1;
                    end else if (sign_q && mag_r > MagW'(32768)) begin
                        quotient_d = 16'h8000;
                        ovf_d      = 1'b1;
                    end else if (sign_q) begin
                        quotient_d = 16'd0 - mag_r[15:0];
                    end else begin
                        quotient_d = mag_r[15:0];
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            numer_q    <= '0;
            qraw_q     <= '0;
            rem_q      <= '0;
            magb_q     <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            sign_a_q   <= 1'b0;
            a_zero_q   <= 1'b0;
            bz_q       <= 1'b0;
            quotient_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            numer_q    <= numer_d;
            qraw_q     <= qraw_d;
            rem_q      <= rem_d;
            magb_q     <= magb_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            sign_a_q   <= sign_a_d;
            a_zero_q   <= a_zero_d;
            bz_q       <= bz_d;
            quotient_q <= quotient_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
        end
    end

    assign quotient    = quotient_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign div_by_zero = dbz_q;

`ifdef FIXED_POINT_DIVIDER_OVERFLOW_FLAG_EN
    assign overflow = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_fixed_point_divider.sv
// Scoreboard bench for fixed_point_divider at default Q1.15 parameters.
module tb_fixed_point_divider;

    localparam int S = 15;

    typedef struct packed {
        logic [15:0] q;
        logic        dbz;
        logic        ovf;
    } exp_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic        dbz;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [15:0] quotient;
    logic        done;
    logic        busy;
    logic        div_by_zero;
`ifdef FIXED_POINT_DIVIDER_OVERFLOW_FLAG_EN
    logic        overflow;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    fixed_point_divider dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .A          (A),
        .B          (B),
        .quotient   (quotient),
        .done       (done),
        .busy       (busy),
        .div_by_zero(div_by_zero)
`ifdef FIXED_POINT_DIVIDER_OVERFLOW_FLAG_EN
        ,
        .overflow   (overflow)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        longint ma, mb, na, q, r, mr;
        logic s;
        e.q = '0; e.dbz = 1'b0; e.ovf = 1'b0;
        ma = a[15] ? 65536 - longint'(a) : longint'(a);
        mb = b[15] ? 65536 - longint'(b) : longint'(b);
        if (b == 16'd0) begin
            e.dbz = 1'b1;
            e.q   = (a == 16'd0) ? 16'h0000 : (a[15] ? 16'h8000 : 16'h7FFF);
            return e;
        end
        s  = a[15] ^ b[15];
        na = ma << S;
        q  = na / mb;
        r  = na % mb;
        mr = q + ((2 * r >= mb) ? 1 : 0);
        if (!s && mr > 32767) begin
            e.q = 16'h7FFF; e.ovf = 1'b1;
        end else if (s && mr > 32768) begin
            e.q = 16'h8000; e.ovf = 1'b1;
        end else begin
            e.q = s ? 16'((65536 - mr) % 65536) : 16'(mr);
        end
        return e;
    endfunction

    // Leaves the caller just after the accepting edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        A = a; B = b; enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc, output bit hit);
        cyc = 0;
        while (done !== 1'b1 && cyc < limit) begin
            @(posedge clk); #1;
            cyc++;
        end
        hit = (done === 1'b1);
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (quotient !== 16'h0000) begin errors++; $display("FAIL reset_quotient got %h want 0000", quotient); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        exp_t e;
        int   bad = 0;
        sb_q.push_back('{q: 16'h4000, dbz: 1'b0, ovf: 1'b0});
        start_op(16'h2000, 16'h4000);
        for (int i = 0; i < 33; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL basic_busy_window bad_cycles %0d want 0", bad); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done_at_33 got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
        e = sb_q.pop_front();
        checks++; if (quotient !== e.q) begin errors++; $display("FAIL basic_quotient got %h want %h", quotient, e.q); end
        checks++; if (div_by_zero !== e.dbz) begin errors++; $display("FAIL basic_dbz got %b want %b", div_by_zero, e.dbz); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
        checks++; if (quotient !== e.q) begin errors++; $display("FAIL basic_quotient_hold got %h want %h", quotient, e.q); end
    endtask

    task automatic test_rounding_saturation();
        vec_t tbl[8];
        exp_t e;
        int   cyc;
        bit   hit;
        tbl[0] = '{a: 16'h2000, b: 16'h6000, q: 16'h2AAB, dbz: 1'b0, ovf: 1'b0};
        tbl[1] = '{a: 16'hE000, b: 16'h6000, q: 16'hD555, dbz: 1'b0, ovf: 1'b0};
        tbl[2] = '{a: 16'hC000, b: 16'h4000, q: 16'h8000, dbz: 1'b0, ovf: 1'b0};
        tbl[3] = '{a: 16'hC000, b: 16'h2000, q: 16'h8000, dbz: 1'b0, ovf: 1'b1};
        tbl[4] = '{a: 16'h4000, b: 16'h2000, q: 16'h7FFF, dbz: 1'b0, ovf: 1'b1};
        tbl[5] = '{a: 16'h8000, b: 16'h8000, q: 16'h7FFF, dbz: 1'b0, ovf: 1'b1};
        tbl[6] = '{a: 16'h0000, b: 16'hC000, q: 16'h0000, dbz: 1'b0, ovf: 1'b0};
        tbl[7] = '{a: 16'h1000, b: 16'hC000, q: 16'hE000, dbz: 1'b0, ovf: 1'b0};
        foreach (tbl[i]) begin
            sb_q.push_back('{q: tbl[i].q, dbz: tbl[i].dbz, ovf: tbl[i].ovf});
            start_op(tbl[i].a, tbl[i].b);
            wait_done(100, cyc, hit);
            checks++; if (!hit || cyc != 33) begin errors++; $display("FAIL round_sat_latency[%0d] got %0d hit %b want 33", i, cyc, hit); end
            e = sb_q.pop_front();
            checks++; if (quotient !== e.q) begin errors++; $display("FAIL round_sat_quotient[%0d] got %h want %h", i, quotient, e.q); end
            checks++; if (div_by_zero !== e.dbz) begin errors++; $display("FAIL round_sat_dbz[%0d] got %b want %b", i, div_by_zero, e.dbz); end
`ifdef FIXED_POINT_DIVIDER_OVERFLOW_FLAG_EN
            checks++; if (overflow !== e.ovf) begin errors++; $display("FAIL round_sat_ovf[%0d] got %b want %b", i, overflow, e.ovf); end
`endif
        end
    endtask

    task automatic test_div_by_zero();
        vec_t tbl[3];
        exp_t e;
        int   cyc;
        bit   hit;
        tbl[0] = '{a: 16'h1234, b: 16'h0000, q: 16'h7FFF, dbz: 1'b1, ovf: 1'b0};
        tbl[1] = '{a: 16'hF000, b: 16'h0000, q: 16'h8000, dbz: 1'b1, ovf: 1'b0};
        tbl[2] = '{a: 16'h0000, b: 16'h0000, q: 16'h0000, dbz: 1'b1, ovf: 1'b0};
        foreach (tbl[i]) begin
            sb_q.push_back('{q: tbl[i].q, dbz: tbl[i].dbz, ovf: tbl[i].ovf});
            start_op(tbl[i].a, tbl[i].b);
            wait_done(100, cyc, hit);
            checks++; if (!hit || cyc != 2) begin errors++; $display("FAIL dbz_latency[%0d] got %0d hit %b want 2", i, cyc, hit); end
            e = sb_q.pop_front();
            checks++; if (quotient !== e.q) begin errors++; $display("FAIL dbz_quotient[%0d] got %h want %h", i, quotient, e.q); end
            checks++; if (div_by_zero !== e.dbz) begin errors++; $display("FAIL dbz_flag[%0d] got %b want %b", i, div_by_zero, e.dbz); end
`ifdef FIXED_POINT_DIVIDER_OVERFLOW_FLAG_EN
            checks++; if (overflow !== e.ovf) begin errors++; $display("FAIL dbz_ovf[%0d] got %b want %b", i, overflow, e.ovf); end
`endif
        end
    endtask

    task automatic test_random();
        exp_t e;
        int   cyc;
        bit   hit;
        logic [15:0] a, b;
        for (int i = 0; i < 12; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 4 == 0) b = 16'($urandom_range(1, 255));
            sb_q.push_back(model(a, b));
            start_op(a, b);
            wait_done(100, cyc, hit);
            checks++; if (!hit || cyc != ((b == 16'd0) ? 2 : 33)) begin errors++; $display("FAIL rand_latency[%0d] got %0d hit %b", i, cyc, hit); end
            e = sb_q.pop_front();
            checks++; if (quotient !== e.q || div_by_zero !== e.dbz) begin errors++; $display("FAIL rand_result[%0d] a %h b %h got %h/%b want %h/%b", i, a, b, quotient, div_by_zero, e.q, e.dbz); end
`ifdef FIXED_POINT_DIVIDER_OVERFLOW_FLAG_EN
            checks++; if (overflow !== e.ovf) begin errors++; $display("FAIL rand_ovf[%0d] got %b want %b", i, overflow, e.ovf); end
`endif
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        bit   hit;
        sb_q.push_back('{q: 16'h2AAB, dbz: 1'b0, ovf: 1'b0});
        start_op(16'h2000, 16'h6000);
        repeat (5) begin @(posedge clk); #1; end
        // Pulse with other operands mid-flight; must not disturb the running divide.
        start_op(16'h7FFF, 16'h0001);
        A = 16'h1111; B = 16'h0000;
        wait_done(100, cyc, hit);
        checks++; if (!hit) begin errors++; $display("FAIL b2b_first_done got timeout want done"); end
        e = sb_q.pop_front();
        checks++; if (quotient !== e.q || div_by_zero !== e.dbz) begin errors++; $display("FAIL b2b_first_result got %h/%b want %h/%b", quotient, div_by_zero, e.q, e.dbz); end
        sb_q.push_back('{q: 16'hD555, dbz: 1'b0, ovf: 1'b0});
        start_op(16'hE000, 16'h6000);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_accept_in_done got busy %b done %b want 1 0", busy, done); end
        wait_done(100, cyc, hit);
        checks++; if (!hit || cyc != 33) begin errors++; $display("FAIL b2b_second_latency got %0d hit %b want 33", cyc, hit); end
        e = sb_q.pop_front();
        checks++; if (quotient !== e.q) begin errors++; $display("FAIL b2b_second_quotient got %h want %h", quotient, e.q); end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL b2b_scoreboard_left got %0d want 0", sb_q.size()); end
    endtask

    task automatic test_reset_mid_op();
        exp_t e;
        int   cyc;
        bit   hit;
        int   seen = 0;
        start_op(16'h4000, 16'h6000);
        repeat (10) begin @(posedge clk); #1; end
        reset = 1'b0;
        #1;
        checks++; if (quotient !== 16'h0000) begin errors++; $display("FAIL midreset_quotient got %h want 0000", quotient); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midreset_busy_done got %b %b want 0 0", busy, done); end
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midreset_no_done got %0d active cycles want 0", seen); end
        sb_q.push_back('{q: 16'h4000, dbz: 1'b0, ovf: 1'b0});
        start_op(16'h2000, 16'h4000);
        wait_done(100, cyc, hit);
        checks++; if (!hit || cyc != 33) begin errors++; $display("FAIL midreset_after_latency got %0d hit %b want 33", cyc, hit); end
        e = sb_q.pop_front();
        checks++; if (quotient !== e.q || div_by_zero !== e.dbz) begin errors++; $display("FAIL midreset_after_result got %h/%b want %h/%b", quotient, div_by_zero, e.q, e.dbz); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding_saturation();
        test_div_by_zero();
        test_random();
        test_back_to_back();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
